reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the synchronous, active-high reset consumed by the design's synchronous-reset flops. It takes the board-level asynchronous reset and releases a set of staged reset outputs in a fixed order, each deasserted cleanly on `clk`. It sits at the top of the single clock domain, between the reset pin / software reset request and every downstream block that uses a synchronous `reset` input.

## Interface
- `SYNC_DEPTH`, default 2: deassertion synchronizer length; legal range ≥2.
- `STRETCH`, default 16: cycles all outputs stay asserted after sync, before the first release; ≥1.
- `NUM_STAGES`, default 3: number of staged reset outputs; ≥1.
- `STAGE_GAP`, default 4: cycles between successive stage releases; ≥1.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `soft_req`  in  1  software reset request; rising edge acts, synchronous to `clk`.
- `rst_out`  out  NUM_STAGES  active-high synchronous resets; bit 0 is released first.
- `ready`  out  1  high once every stage is released.

## Operation
- Under `reset` high, all outputs are forced immediately and asynchronously, without waiting for `clk`:
  - `rst_out` = all ones, `ready` = 0, state = HOLD.
  - Synchronizer flops = 1, counter = 0, `soft_req_q` = 0.
- FSM states: HOLD, STRETCH, RELEASE, RUN.
  - HOLD → STRETCH when synchronizer output is 0; counter cleared.
  - STRETCH: counter increments each cycle. When counter == STRETCH-1: clear `rst_out[0]`, clear the counter, go to RELEASE. If NUM_STAGES = 1, go straight to RUN and set `ready`.
  - RELEASE: counter increments each cycle. When counter == STAGE_GAP-1: clear the next `rst_out` bit and clear the counter. If that bit is bit NUM_STAGES-1, go to RUN and set `ready` on the same edge.
  - RUN: holds all outputs.
- Soft reset:
  - Trigger = `soft_req & ~soft_req_q & (state == RUN)`.
  - On trigger: `rst_out` <= all ones, `ready` <= 0, counter <= 0, state <= STRETCH.
  - No HOLD or synchronizer pass for a soft reset.
  - `soft_req` edges outside RUN are ignored and not queued. Holding `soft_req` high produces exactly one sequence.
- `rst_out` bits only ever go 1→0 in index order. Once a bit is released it stays 0 until the next reset or trigger.
- Counter width: `$clog2(max(STRETCH, STAGE_GAP)+1)`. The counter never wraps, because it is cleared on each transition.

## Timing
- `reset` deassertion synchronizer:
  - Let edge 1 be the first `clk` rising edge after `reset` falls.
  - The synchronizer output goes 0 after edge SYNC_DEPTH; HOLD→STRETCH happens at edge SYNC_DEPTH+1.
  - `rst_out[0]` falls at edge SYNC_DEPTH+1+STRETCH.
  - `rst_out[i]` falls STAGE_GAP·i edges after that. `ready` rises with the last stage.
  - Defaults: stage0 at edge 19, stage1 at 23, stage2 at 27; `ready` at 27.
- Soft trigger sampled at edge k:
  - `rst_out` = all ones and `ready` = 0 from edge k.
  - Stage0 falls at k+STRETCH, stage i at k+STRETCH+STAGE_GAP·i. Defaults: k+16, k+20, k+24.
- `reset` asserted in any state, including mid-RELEASE or coincident with a soft trigger:
  - Asynchronous return to the reset values.
  - The sequence restarts fully from HOLD.
- All output changes other than async assertion occur on `clk` rising edges. Outputs are registered, with no combinational path from inputs.

## Structure
- Package `reset_seq_pkg`: enum `rst_seq_state_t` {HOLD, STRETCH, RELEASE, RUN}.
- Sub-module `reset_sync_chain`, parameterised by SYNC_DEPTH:
  - Async-set, sync-clear shift chain; input tied 0.
  - Output = last flop.
- Top holds the FSM, counter, stage index, `soft_req_q` and output registers.

## Test plan
- Power-on: `reset` high 5 cycles then low → `rst_out` = 3'b111 until edge 19; 3'b110 at 19, 3'b100 at 23, 3'b000 and `ready` = 1 at 27.
- Async assert: in RUN, raise `reset` between edges → `rst_out` = 3'b111 and `ready` = 0 before the next edge; on release, the sequence repeats with the power-on timing.
- Soft reset: in RUN, `soft_req` pulse sampled at edge k → 3'b111 at k; 3'b110 at k+16, 3'b100 at k+20, 3'b000 and `ready` at k+24.
- `soft_req` held high 100 cycles from RUN → exactly one sequence; no retrigger after `ready` returns.
- `soft_req` pulse during STRETCH or RELEASE → ignored; release edges unchanged from the original schedule.
- `reset` pulse at edge 21 (stage0 released) → immediate 3'b111, then full restart; stage0 falls 19 edges after the new deassertion.

Source files
------------

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared state type and helpers for the staged reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer phases: waiting on the synchronizer, holding all stages,
    // releasing stages one by one, and fully running.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_t;

    // Larger of two integers, used when sizing the shared cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync_chain
//  Description : Asynchronous-assert, synchronous-deassert reset synchronizer.
//                All flops set immediately on reset; zeros shift in on clk so
//                the output falls SYNC_DEPTH edges after reset is removed.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sync_chain #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_rst
);

    logic [SYNC_DEPTH-1:0] r_chain;

    // Set every stage asynchronously; shift a constant zero in on each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign sync_rst = r_chain[SYNC_DEPTH-1];

endmodule : reset_sync_chain
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Converts the board asynchronous reset (and a software reset
//                request) into NUM_STAGES synchronous active-high resets that
//                are released in index order, then raises ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_DEPTH = 2,
    parameter int STRETCH    = 16,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready
);

    import reset_seq_pkg::*;

    // The counter only ever needs to reach the longer of the two intervals,
    // since it is cleared at every phase change.
    localparam int CNT_W = $clog2(max_int(STRETCH, STAGE_GAP) + 1);
    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] C_STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] C_LAST_STAGE   = STG_W'(NUM_STAGES - 1);

    rst_seq_state_t        r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [STG_W-1:0]      r_stage;
    logic                  r_soft_q;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic                  w_sync_rst;
    logic                  w_soft_trig;

    reset_sync_chain #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sync_rst (w_sync_rst)
    );

    // A software request only counts on its rising edge, and only once the
    // sequence has completed; edges seen elsewhere are dropped, not queued.
    assign w_soft_trig = soft_req & ~r_soft_q & (r_state == reset_seq_pkg::RUN);

    // Sequencer FSM with registered stage resets and ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= reset_seq_pkg::HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_soft_q  <= 1'b0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
        end else begin
            r_soft_q <= soft_req;
            if (w_soft_trig) begin
                // Software reset skips HOLD: the clock is already known good.
                r_rst_out <= '1;
                r_ready   <= 1'b0;
                r_cnt     <= '0;
                r_stage   <= '0;
                r_state   <= reset_seq_pkg::STRETCH;
            end else begin
                case (r_state)
                    reset_seq_pkg::HOLD: begin
                        if (!w_sync_rst) begin
                            r_cnt   <= '0;
                            r_state <= reset_seq_pkg::STRETCH;
                        end
                    end
                    reset_seq_pkg::STRETCH: begin
                        if (r_cnt == C_STRETCH_LAST) begin
                            r_rst_out[0] <= 1'b0;
                            r_cnt        <= '0;
                            if (NUM_STAGES == 1) begin
                                r_ready <= 1'b1;
                                r_state <= reset_seq_pkg::RUN;
                            end else begin
                                r_stage <= STG_W'(1);
                                r_state <= reset_seq_pkg::RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    reset_seq_pkg::RELEASE: begin
                        if (r_cnt == C_GAP_LAST) begin
                            r_rst_out[r_stage] <= 1'b0;
                            r_cnt              <= '0;
                            if (r_stage == C_LAST_STAGE) begin
                                r_ready <= 1'b1;
                                r_state <= reset_seq_pkg::RUN;
                            end else begin
                                r_stage <= r_stage + STG_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    reset_seq_pkg::RUN: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= reset_seq_pkg::HOLD;
                    end
                endcase
            end
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Self-checking bench for reset_sequencer (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int SYNC_DEPTH = 2;
    localparam int STRETCH    = 16;
    localparam int NUM_STAGES = 3;
    localparam int STAGE_GAP  = 4;

    logic                  clk      = 1'b0;
    logic                  reset    = 1'b0;
    logic                  soft_req = 1'b0;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  ready;

    reset_sequencer #(
        .SYNC_DEPTH (SYNC_DEPTH),
        .STRETCH    (STRETCH),
        .NUM_STAGES (NUM_STAGES),
        .STAGE_GAP  (STAGE_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .soft_req (soft_req),
        .rst_out  (rst_out),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: the schedule is anchored at a "base" edge (the edge
    // counting starts from); stage i is released at base+STRETCH+GAP*i.
    int                    n       = 0;
    int                    base    = -1;
    int                    low_cnt = 0;
    bit                    prev_soft = 1'b0;
    bit                    m_ready = 1'b0;
    logic [NUM_STAGES-1:0] m_rst   = '1;

    typedef struct {
        int                    edge_no;
        logic [NUM_STAGES-1:0] exp_rst;
        logic                  exp_ready;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [NUM_STAGES:0] act,
                         input logic [NUM_STAGES:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got {ready,rst_out}=%b, expected %b",
                     name, n, act, exp);
        end
    endtask

    task automatic model_edge();
        n++;
        if (reset) begin
            base      = -1;
            low_cnt   = 0;
            prev_soft = 1'b0;
        end else begin
            low_cnt++;
            if (base < 0 && low_cnt == SYNC_DEPTH + 1) base = n;
            if (soft_req && !prev_soft && m_ready) base = n;
            prev_soft = soft_req;
        end
        if (base < 0) begin
            m_rst   = '1;
            m_ready = 1'b0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++)
                m_rst[i] = (n < base + STRETCH + STAGE_GAP * i);
            m_ready = (n >= base + STRETCH + STAGE_GAP * (NUM_STAGES - 1));
        end
    endtask

    // One clock: advance the model on the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", {ready, rst_out}, {m_ready, m_rst});
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic run_low_to(input int target);
        while (low_cnt < target) step();
    endtask

    task automatic soft_pulse();
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        vecs[0] = '{1,  3'b111, 1'b0};
        vecs[1] = '{18, 3'b111, 1'b0};
        vecs[2] = '{19, 3'b110, 1'b0};
        vecs[3] = '{22, 3'b110, 1'b0};
        vecs[4] = '{23, 3'b100, 1'b0};
        vecs[5] = '{26, 3'b100, 1'b0};
        vecs[6] = '{27, 3'b000, 1'b1};
        vecs[7] = '{40, 3'b000, 1'b1};

        // Power-on reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1 check("reset_state", {ready, rst_out}, 4'b0111);
        repeat (5) step();
        reset = 1'b0;

        // Power-on release schedule from the table.
        for (int i = 0; i < 8; i++) begin
            run_low_to(vecs[i].edge_no);
            check("poweron_vec", {ready, rst_out}, {vecs[i].exp_ready, vecs[i].exp_rst});
        end

        // Soft reset pulse from RUN.
        soft_pulse();
        k = n;
        check("soft_at_k", {ready, rst_out}, 4'b0111);
        run_to(k + 15); check("soft_k15", {ready, rst_out}, 4'b0111);
        run_to(k + 16); check("soft_k16", {ready, rst_out}, 4'b0110);
        run_to(k + 20); check("soft_k20", {ready, rst_out}, 4'b0100);
        run_to(k + 23); check("soft_k23", {ready, rst_out}, 4'b0100);
        run_to(k + 24); check("soft_k24", {ready, rst_out}, 4'b1000);

        // Held request yields a single sequence.
        run_to(n + 3);
        soft_req = 1'b1;
        step();
        k = n;
        run_to(k + 24); check("held_done", {ready, rst_out}, 4'b1000);
        run_to(k + 60); check("held_no_retrig", {ready, rst_out}, 4'b1000);
        run_to(k + 100); check("held_end", {ready, rst_out}, 4'b1000);
        soft_req = 1'b0;
        run_to(n + 3);

        // Requests during STRETCH and RELEASE are ignored.
        soft_pulse();
        k = n;
        run_to(k + 5);
        soft_pulse();
        run_to(k + 17);
        soft_pulse();
        run_to(k + 16); check("ign_k16", {ready, rst_out}, 4'b0110);
        run_to(k + 20); check("ign_k20", {ready, rst_out}, 4'b0100);
        run_to(k + 24); check("ign_k24", {ready, rst_out}, 4'b1000);
        run_to(k + 30); check("ign_k30", {ready, rst_out}, 4'b1000);

        // Asynchronous assertion from RUN, visible before the next edge.
        reset = 1'b1;
        #1 check("async_assert", {ready, rst_out}, 4'b0111);
        step();
        step();
        reset = 1'b0;
        run_low_to(18); check("async_r18", {ready, rst_out}, 4'b0111);
        run_low_to(19); check("async_r19", {ready, rst_out}, 4'b0110);
        run_low_to(27); check("async_r27", {ready, rst_out}, 4'b1000);

        // Reset pulse right after stage0 release restarts the whole sequence.
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_low_to(21); check("mid_r21", {ready, rst_out}, 4'b0110);
        reset = 1'b1;
        #1 check("mid_async", {ready, rst_out}, 4'b0111);
        step();
        reset = 1'b0;
        run_low_to(18); check("mid_restart18", {ready, rst_out}, 4'b0111);
        run_low_to(19); check("mid_restart19", {ready, rst_out}, 4'b0110);
        run_low_to(27); check("mid_restart27", {ready, rst_out}, 4'b1000);

        // Randomized soft requests and occasional reset pulses vs. the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) soft_req = ~soft_req;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1 check("rand_async", {ready, rst_out}, 4'b0111);
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
